// File: rtl/regfile_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
//   Shared definitions for the register-file writeback arbiter slice.
//   - Default register-file geometry (register count, pending counter width)
//   - Register address and data widths
//   - Writeback source encoding (ALU / LSU), also used as the arbiter
//     request/grant bit index and as the round-robin pointer value
//   - Writeback result record and the "is this register tracked" helper
// ---------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

    localparam int NR_REG_DEFAULT = 16;
    localparam int PEND_W_DEFAULT = 2;
    localparam int REG_AW         = 5;
    localparam int DATA_W         = 32;

    // Source encoding doubles as the bit position in req/gnt vectors.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_result_t;

    // x0 is hardwired zero and addresses at or beyond nr_reg do not exist,
    // so neither is ever written nor tracked by the pending scoreboard.
    function automatic logic reg_tracked(input logic [REG_AW-1:0] rd,
                                         input int                nr_reg);
        return (rd != '0) && (int'(rd) < nr_reg);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-requester round-robin arbiter. Grant is combinational from the
//   request vector and the pointer; the pointer moves to the other requester
//   after every grant so a continuously requesting source cannot starve the
//   other one.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (pointer returns to SRC_ALU)
//   req  - request vector, indexed by wb_src_e
//   gnt  - one-hot (or zero) grant vector, indexed by wb_src_e
// ---------------------------------------------------------------------------
module rr_arb2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    wb_src_e ptr_reg;
    wb_src_e ptr_next;

    // The pointer only matters when both sources request; a lone requester
    // is always granted.
    always_comb begin
        gnt = 2'b00;
        if (req[SRC_ALU] && (!req[SRC_LSU] || ptr_reg == SRC_ALU)) begin
            gnt[SRC_ALU] = 1'b1;
        end else if (req[SRC_LSU]) begin
            gnt[SRC_LSU] = 1'b1;
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (gnt[SRC_ALU]) begin
            ptr_next = SRC_LSU;
        end else if (gnt[SRC_LSU]) begin
            ptr_next = SRC_ALU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= SRC_ALU;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//   Write-side companion of the integer register file. Merges ALU and LSU
//   writeback results onto the single register-file write port and keeps a
//   per-register pending-write scoreboard so decode can detect RAW hazards.
//
// Parameters:
//   NR_REG  - number of architectural registers (x0 never tracked)
//   PEND_W  - width of each pending counter; 2^PEND_W-1 writes in flight
//
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   iss_valid/iss_ready/iss_rd     - destination reservation from issue
//   alu_valid/alu_ready/alu_rd/alu_data - ALU writeback source
//   lsu_valid/lsu_ready/lsu_rd/lsu_data - load writeback source
//   wen/waddr/wdata                - registered register-file write port
//   raddr1/raddr2                  - decode read addresses
//   busy1/busy2                    - read address has a pending write
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NR_REG = NR_REG_DEFAULT,
    parameter int PEND_W = PEND_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [REG_AW-1:0] iss_rd,

    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,

    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,

    output logic              wen,
    output logic [REG_AW-1:0] waddr,
    output logic [DATA_W-1:0] wdata,

    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic              busy1,
    output logic              busy2
);

    // -----------------------------------------------------------------------
    // Writeback arbitration
    // -----------------------------------------------------------------------
    logic [1:0] wb_req;
    logic [1:0] wb_gnt;
    wb_result_t wb_sel;
    logic       wb_fire;
    logic       wb_commit;

    assign wb_req[SRC_ALU] = alu_valid;
    assign wb_req[SRC_LSU] = lsu_valid;

    rr_arb2 u_rr_arb2 (
        .clk (clk),
        .rst (rst),
        .req (wb_req),
        .gnt (wb_gnt)
    );

    // Ready is the grant itself, so a grant is always a completed transfer.
    assign alu_ready = wb_gnt[SRC_ALU];
    assign lsu_ready = wb_gnt[SRC_LSU];
    assign wb_fire   = |wb_gnt;

    always_comb begin
        if (wb_gnt[SRC_LSU]) begin
            wb_sel.rd   = lsu_rd;
            wb_sel.data = lsu_data;
        end else begin
            wb_sel.rd   = alu_rd;
            wb_sel.data = alu_data;
        end
    end

    // Results for x0 or non-existent registers are consumed but dropped.
    assign wb_commit = wb_fire && reg_tracked(wb_sel.rd, NR_REG);

    // -----------------------------------------------------------------------
    // Registered write port. Address/data only change on a real write so the
    // port holds its last value while idle.
    // -----------------------------------------------------------------------
    logic              wen_reg;
    logic [REG_AW-1:0] waddr_reg;
    logic [DATA_W-1:0] wdata_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            wen_reg   <= 1'b0;
            waddr_reg <= '0;
            wdata_reg <= '0;
        end else begin
            wen_reg <= wb_commit;
            if (wb_commit) begin
                waddr_reg <= wb_sel.rd;
                wdata_reg <= wb_sel.data;
            end
        end
    end

    assign wen   = wen_reg;
    assign waddr = waddr_reg;
    assign wdata = wdata_reg;

    // -----------------------------------------------------------------------
    // Pending-write scoreboard
    // -----------------------------------------------------------------------
    logic              iss_fire;
    logic [NR_REG-1:0] pend_nz;
    logic [NR_REG-1:0] pend_full;

    assign iss_fire = iss_valid && iss_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NR_REG; gi++) begin : g_pend
            if (gi == 0) begin : g_x0
                assign pend_nz[gi]   = 1'b0;
                assign pend_full[gi] = 1'b0;
            end else begin : g_cnt
                logic [PEND_W-1:0] count_reg;
                logic [PEND_W-1:0] count_next;
                logic              inc;
                logic              dec;

                assign inc = iss_fire && (iss_rd == REG_AW'(gi));
                // Retire on the same edge the register file captures the
                // value, so busy falls exactly when the data is readable.
                assign dec = wen_reg && (waddr_reg == REG_AW'(gi));

                always_comb begin
                    count_next = count_reg;
                    if (inc && !dec) begin
                        count_next = count_reg + 1'b1;
                    end else if (dec && !inc) begin
                        // Underflow is a protocol error; hold at zero.
                        if (count_reg != '0) begin
                            count_next = count_reg - 1'b1;
                        end
                    end
                end

                always_ff @(posedge clk) begin
                    if (rst) begin
                        count_reg <= '0;
                    end else begin
                        count_reg <= count_next;
                    end
                end

                assign pend_nz[gi]   = |count_reg;
                assign pend_full[gi] = &count_reg;

                a_no_underflow : assert property (
                    @(posedge clk) disable iff (rst)
                    !(dec && !inc && count_reg == '0)
                );
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Address lookups. Untracked addresses never match a set bit (entry 0 is
    // constant zero and out-of-range addresses match no entry), so they read
    // as not busy and never block issue.
    // -----------------------------------------------------------------------
    logic busy1_w;
    logic busy2_w;
    logic iss_full_w;

    always_comb begin
        busy1_w    = 1'b0;
        busy2_w    = 1'b0;
        iss_full_w = 1'b0;
        for (int i = 0; i < NR_REG; i++) begin
            if (raddr1 == REG_AW'(i)) busy1_w    = busy1_w    | pend_nz[i];
            if (raddr2 == REG_AW'(i)) busy2_w    = busy2_w    | pend_nz[i];
            if (iss_rd == REG_AW'(i)) iss_full_w = iss_full_w | pend_full[i];
        end
    end

    assign busy1     = busy1_w;
    assign busy2     = busy2_w;
    assign iss_ready = !iss_full_w;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//   Directed self-checking bench for regfile_wb_arbiter (NR_REG=16, PEND_W=2).
//   Inputs change 1 time unit after the rising edge; outputs are compared
//   1 time unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        iss_valid;
    logic        iss_ready;
    logic [4:0]  iss_rd;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        busy1;
    logic        busy2;

    int errors = 0;
    int checks = 0;

    regfile_wb_arbiter #(
        .NR_REG (16),
        .PEND_W (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_rd    (iss_rd),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .busy1     (busy1),
        .busy2     (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One line per register-file write transaction.
    always @(negedge clk) begin
        if (wen === 1'b1) $display("  wb write: waddr=%0d wdata=%08h", waddr, wdata);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_idle();
        iss_valid = 1'b0; iss_rd = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        raddr1 = '0; raddr2 = '0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        $display("test_reset");
        rst = 1'b1;
        drive_idle();
        tick();
        tick();
        rst = 1'b0;
        raddr1 = 5'd5; raddr2 = 5'd0; iss_rd = 5'd5;
        settle();
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %0d expected 0", wen); end
        checks++; if (waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr: got %0d expected 0", waddr); end
        checks++; if (wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %08h expected 00000000", wdata); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %0d expected 0", busy1); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy2: got %0d expected 0", busy2); end
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL reset_iss_ready: got %0d expected 1", iss_ready); end
        checks++; if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin errors++; $display("FAIL reset_idle_ready: got alu=%0d lsu=%0d expected 0 0", alu_ready, lsu_ready); end
        tick();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_single_write();
        $display("test_single_write");
        raddr1 = 5'd5;
        iss_valid = 1'b1; iss_rd = 5'd5;
        settle();
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sw_iss_ready: got %0d expected 1", iss_ready); end
        tick();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        settle();
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL sw_busy_before: got %0d expected 1", busy1); end
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL sw_alu_ready: got %0d expected 1", alu_ready); end
        tick();
        alu_valid = 1'b0;
        settle();
        checks++; if (wen !== 1'b1) begin errors++; $display("FAIL sw_wen: got %0d expected 1", wen); end
        checks++; if (waddr !== 5'd5) begin errors++; $display("FAIL sw_waddr: got %0d expected 5", waddr); end
        checks++; if (wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %08h expected deadbeef", wdata); end
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL sw_busy_wen_cycle: got %0d expected 1", busy1); end
        tick();
        settle();
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL sw_busy_after: got %0d expected 0", busy1); end
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL sw_wen_after: got %0d expected 0", wen); end
        checks++; if (waddr !== 5'd5) begin errors++; $display("FAIL sw_waddr_hold: got %0d expected 5", waddr); end
        tick();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_lsu_rd0();
        $display("test_lsu_rd0");
        raddr1 = 5'd0;
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h55;
        settle();
        checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL rd0_lsu_ready: got %0d expected 1", lsu_ready); end
        checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL rd0_alu_ready: got %0d expected 0", alu_ready); end
        tick();
        lsu_valid = 1'b0;
        settle();
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL rd0_wen: got %0d expected 0", wen); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rd0_busy1: got %0d expected 0", busy1); end
        checks++; if (wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd0_wdata_hold: got %08h expected deadbeef", wdata); end
        tick();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_back_to_back();
        $display("test_back_to_back");
        iss_valid = 1'b1; iss_rd = 5'd3; tick();
        iss_rd = 5'd3; tick();
        iss_rd = 5'd4; tick();
        iss_valid = 1'b0;
        raddr1 = 5'd3; raddr2 = 5'd4;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
        settle();
        checks++; if (busy1 !== 1'b1 || busy2 !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %0d %0d expected 1 1", busy1, busy2); end
        checks++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin errors++; $display("FAIL b2b_c0_ready: got alu=%0d lsu=%0d expected 1 0", alu_ready, lsu_ready); end
        tick();
        alu_data = 32'h33;  // second ALU result to x3, both still valid
        settle();
        checks++; if (alu_ready !== 1'b0 || lsu_ready !== 1'b1) begin errors++; $display("FAIL b2b_c1_ready: got alu=%0d lsu=%0d expected 0 1", alu_ready, lsu_ready); end
        checks++; if (wen !== 1'b1 || waddr !== 5'd3 || wdata !== 32'h11) begin errors++; $display("FAIL b2b_wr0: got wen=%0d waddr=%0d wdata=%08h expected 1 3 00000011", wen, waddr, wdata); end
        tick();
        lsu_valid = 1'b0;
        settle();
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL b2b_c2_alu_ready: got %0d expected 1", alu_ready); end
        checks++; if (wen !== 1'b1 || waddr !== 5'd4 || wdata !== 32'h22) begin errors++; $display("FAIL b2b_wr1: got wen=%0d waddr=%0d wdata=%08h expected 1 4 00000022", wen, waddr, wdata); end
        tick();
        alu_valid = 1'b0;
        settle();
        checks++; if (wen !== 1'b1 || waddr !== 5'd3 || wdata !== 32'h33) begin errors++; $display("FAIL b2b_wr2: got wen=%0d waddr=%0d wdata=%08h expected 1 3 00000033", wen, waddr, wdata); end
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL b2b_busy3_last: got %0d expected 1", busy1); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL b2b_busy4_clear: got %0d expected 0", busy2); end
        tick();
        settle();
        checks++; if (wen !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL b2b_drain: got wen=%0d busy1=%0d expected 0 0", wen, busy1); end
        tick();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_pending_limit();
        $display("test_pending_limit");
        raddr1 = 5'd7; raddr2 = 5'd0;
        iss_valid = 1'b1; iss_rd = 5'd7;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL pend_issue%0d_ready: got %0d expected 1", i, iss_ready); end
            tick();
        end
        settle();
        checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL pend_full_ready: got %0d expected 0", iss_ready); end
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        tick();
        alu_data = 32'h78;
        settle();
        checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL pend_wen_cycle_ready: got %0d expected 0", iss_ready); end
        checks++; if (wen !== 1'b1 || waddr !== 5'd7) begin errors++; $display("FAIL pend_wr0: got wen=%0d waddr=%0d expected 1 7", wen, waddr); end
        tick();
        alu_valid = 1'b0;
        settle();
        // One write retired (count 2); issue fires on the same edge as wen.
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL pend_after_commit_ready: got %0d expected 1", iss_ready); end
        checks++; if (wen !== 1'b1 || wdata !== 32'h78) begin errors++; $display("FAIL pend_wr1: got wen=%0d wdata=%08h expected 1 00000078", wen, wdata); end
        tick();
        iss_valid = 1'b0;
        settle();
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL pend_same_edge_ready: got %0d expected 1", iss_ready); end
        checks++; if (busy1 !== 1'b1 || wen !== 1'b0) begin errors++; $display("FAIL pend_same_edge_busy: got busy1=%0d wen=%0d expected 1 0", busy1, wen); end
        tick();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset_midflight();
        $display("test_reset_midflight");
        iss_valid = 1'b1; iss_rd = 5'd2;
        tick();
        iss_valid = 1'b0;
        raddr1 = 5'd2; raddr2 = 5'd7;
        settle();
        checks++; if (busy1 !== 1'b1 || busy2 !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %0d %0d expected 1 1", busy1, busy2); end
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hAA;
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hBB;
        settle();
        checks++; if (lsu_ready !== 1'b1 || alu_ready !== 1'b0) begin errors++; $display("FAIL rst_pre_ptr: got alu=%0d lsu=%0d expected 0 1", alu_ready, lsu_ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        checks++; if (wen !== 1'b0 || waddr !== 5'd0 || wdata !== 32'h0) begin errors++; $display("FAIL rst_port: got wen=%0d waddr=%0d wdata=%08h expected 0 0 00000000", wen, waddr, wdata); end
        checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0d %0d expected 0 0", busy1, busy2); end
        checks++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin errors++; $display("FAIL rst_alu_first: got alu=%0d lsu=%0d expected 1 0", alu_ready, lsu_ready); end
        tick();
        alu_valid = 1'b0;
        settle();
        checks++; if (lsu_ready !== 1'b1 || wen !== 1'b0) begin errors++; $display("FAIL rst_lsu_next: got lsu=%0d wen=%0d expected 1 0", lsu_ready, wen); end
        tick();
        lsu_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_single_write();
        test_lsu_rd0();
        test_back_to_back();
        test_pending_limit();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
